// File: rtl/if_id_stage_pkg.sv
// Shared constants and instruction field helpers for the IF/ID pipeline stage.
package if_id_stage_pkg;

   localparam logic [15:0] NOP_INSTR = 16'h0800;
   localparam logic [4:0]  HALT_OP   = 5'b00000;

   typedef logic [15:0] instr_t;
   typedef logic [2:0]  reg_idx_t;

   function automatic logic [4:0] op_of(instr_t instr);
      return instr[15:11];
   endfunction

   function automatic reg_idx_t rs_of(instr_t instr);
      return instr[10:8];
   endfunction

   function automatic reg_idx_t rt_of(instr_t instr);
      return instr[7:5];
   endfunction

endpackage

// File: rtl/if_id_stage_if.sv
// Fetch/decode-facing signal bundle of the IF/ID stage.
interface if_id_stage_if;
   import if_id_stage_pkg::*;

   instr_t   instr_in;
   logic [15:0] pc2_in;
   logic     err_in;
   logic     flush;
   logic     ext_stall;
   logic     use_rs;
   logic     use_rt;
   logic     idex_valid;
   logic     idex_mem_read;
   reg_idx_t idex_rd;
   instr_t   instr_out;
   logic [15:0] pc2_out;
   logic     valid_out;
   logic     err_out;
   logic     stall_out;
   logic     bubble_out;
   logic     halt_out;

   modport master (
      output instr_in, pc2_in, err_in, flush, ext_stall, use_rs, use_rt,
             idex_valid, idex_mem_read, idex_rd,
      input  instr_out, pc2_out, valid_out, err_out, stall_out, bubble_out, halt_out
   );

   modport slave (
      input  instr_in, pc2_in, err_in, flush, ext_stall, use_rs, use_rt,
             idex_valid, idex_mem_read, idex_rd,
      output instr_out, pc2_out, valid_out, err_out, stall_out, bubble_out, halt_out
   );

endinterface

// File: rtl/if_id_hazard.sv
// Combinational load-use hazard, halt, stall and bubble generation for IF/ID.
module if_id_hazard
   import if_id_stage_pkg::*;
(
   input  logic     valid,
   input  instr_t   instr,
   input  logic     use_rs,
   input  logic     use_rt,
   input  logic     idex_valid,
   input  logic     idex_mem_read,
   input  reg_idx_t idex_rd,
   input  logic     ext_stall,
   input  logic     flush,
   output logic     hazard,
   output logic     halt,
   output logic     stall,
   output logic     bubble
);

   logic rs_match;
   logic rt_match;

   // R0 is a real register, so all three index bits take part in the match.
   assign rs_match = use_rs & (idex_rd == rs_of(instr));
   assign rt_match = use_rt & (idex_rd == rt_of(instr));

   assign hazard = valid & idex_valid & idex_mem_read & (rs_match | rt_match);
   assign halt   = valid & (op_of(instr) == HALT_OP);
   assign stall  = hazard | ext_stall | halt;
   assign bubble = hazard & ~flush;

endmodule

// File: rtl/if_id_stage_reg16.sv
// 16-bit register cell with synchronous reset and load enable.
module if_id_stage_reg16 #(
   parameter logic [15:0] RstVal = 16'h0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic [15:0] d,
   output logic [15:0] q
);

   always_ff @(posedge clk) begin
      if (rst) begin
         q <= RstVal;
      end else if (en) begin
         q <= d;
      end
   end

endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline register with load-use hazard detection, flush and HALT hold.
module if_id_stage
   import if_id_stage_pkg::*;
(
   input logic         clk,
   input logic         rst,
   if_id_stage_if.slave bus
);

   logic   hazard;
   logic   halt;
   logic   stall;
   logic   bubble;
   logic   load_en;
   instr_t instr_d;
   instr_t instr_q;
   logic [15:0] pc2_q;
   logic   valid_q;
   logic   err_q;

   if_id_hazard u_hazard (
      .valid         (valid_q),
      .instr         (instr_q),
      .use_rs        (bus.use_rs),
      .use_rt        (bus.use_rt),
      .idex_valid    (bus.idex_valid),
      .idex_mem_read (bus.idex_mem_read),
      .idex_rd       (bus.idex_rd),
      .ext_stall     (bus.ext_stall),
      .flush         (bus.flush),
      .hazard        (hazard),
      .halt          (halt),
      .stall         (stall),
      .bubble        (bubble)
   );

   // Flush beats every stall source, so a speculative HALT can be squashed.
   assign load_en = bus.flush | ~stall;
   assign instr_d = bus.flush ? NOP_INSTR : bus.instr_in;

   if_id_stage_reg16 #(
      .RstVal (NOP_INSTR)
   ) u_instr_reg (
      .clk (clk),
      .rst (rst),
      .en  (load_en),
      .d   (instr_d),
      .q   (instr_q)
   );

   if_id_stage_reg16 #(
      .RstVal (16'h0000)
   ) u_pc2_reg (
      .clk (clk),
      .rst (rst),
      .en  (load_en),
      .d   (bus.pc2_in),
      .q   (pc2_q)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else if (load_en) begin
         valid_q <= ~bus.flush;
         err_q   <= ~bus.flush & bus.err_in;
      end
   end

   assign bus.instr_out  = instr_q;
   assign bus.pc2_out    = pc2_q;
   assign bus.valid_out  = valid_q;
   assign bus.err_out    = err_q & valid_q;
   assign bus.stall_out  = stall;
   assign bus.bubble_out = bubble;
   assign bus.halt_out   = halt;

endmodule

// File: tb/tb_if_id_stage.sv
// Self-checking bench for if_id_stage: directed table, corner sequences, random vs model.
module tb_if_id_stage;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   if_id_stage_if bus ();

   if_id_stage dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] instr;
      logic        use_rs;
      logic        use_rt;
      logic        idex_valid;
      logic        idex_mem_read;
      logic [2:0]  idex_rd;
      logic        ext_stall;
      logic        flush;
      logic        exp_stall;
      logic        exp_bubble;
      logic        exp_halt;
   } vec_t;

   vec_t vecs[12];

   // Behavioural reference state
   logic [15:0] m_instr;
   logic [15:0] m_pc2;
   logic        m_valid;
   logic        m_err;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.instr_in      = 16'h0000;
      bus.pc2_in        = 16'h0000;
      bus.err_in        = 1'b0;
      bus.flush         = 1'b0;
      bus.ext_stall     = 1'b0;
      bus.use_rs        = 1'b0;
      bus.use_rt        = 1'b0;
      bus.idex_valid    = 1'b0;
      bus.idex_mem_read = 1'b0;
      bus.idex_rd       = 3'd0;
   endtask

   // Flush then load one instruction so it sits valid in IF/ID.
   task automatic place(input logic [15:0] instr, input logic [15:0] pc2, input logic err);
      idle_inputs();
      bus.flush = 1'b1;
      tick();
      bus.flush    = 1'b0;
      bus.instr_in = instr;
      bus.pc2_in   = pc2;
      bus.err_in   = err;
      tick();
   endtask

   function automatic logic is_hazard(input logic [15:0] instr, input logic valid);
      logic hit;
      hit = 1'b0;
      if (bus.use_rs && bus.idex_rd == instr[10:8]) hit = 1'b1;
      if (bus.use_rt && bus.idex_rd == instr[7:5])  hit = 1'b1;
      return valid && bus.idex_valid && bus.idex_mem_read && hit;
   endfunction

   initial begin
      logic        e_haz;
      logic        e_halt;
      logic        e_stall;
      logic [15:0] rnd;

      checks   = 0;
      failures = 0;
      idle_inputs();

      vecs[0]  = '{16'hD9A0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      vecs[1]  = '{16'hD9A0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[2]  = '{16'hD9A0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[3]  = '{16'hD9A0, 1'b0, 1'b1, 1'b1, 1'b1, 3'd5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      vecs[4]  = '{16'hD9A0, 1'b0, 1'b1, 1'b1, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[5]  = '{16'h1800, 1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      vecs[6]  = '{16'hD9A0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[7]  = '{16'hD9A0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[8]  = '{16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      vecs[9]  = '{16'hD9A0, 1'b1, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[10] = '{16'hD9A0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[11] = '{16'hD9A0, 1'b1, 1'b1, 1'b1, 1'b1, 3'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

      // Reset then load
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst_instr", bus.instr_out, 16'h0800);
      chk("rst_pc2", bus.pc2_out, 16'h0000);
      chk("rst_valid", {15'd0, bus.valid_out}, 16'd0);
      chk("rst_err", {15'd0, bus.err_out}, 16'd0);
      chk("rst_stall", {15'd0, bus.stall_out}, 16'd0);
      chk("rst_halt", {15'd0, bus.halt_out}, 16'd0);
      bus.instr_in = 16'hC123;
      bus.pc2_in   = 16'h0002;
      tick();
      chk("load_instr", bus.instr_out, 16'hC123);
      chk("load_pc2", bus.pc2_out, 16'h0002);
      chk("load_valid", {15'd0, bus.valid_out}, 16'd1);
      chk("load_stall", {15'd0, bus.stall_out}, 16'd0);

      // Combinational table
      foreach (vecs[i]) begin
         place(vecs[i].instr, 16'h0010, 1'b0);
         bus.use_rs        = vecs[i].use_rs;
         bus.use_rt        = vecs[i].use_rt;
         bus.idex_valid    = vecs[i].idex_valid;
         bus.idex_mem_read = vecs[i].idex_mem_read;
         bus.idex_rd       = vecs[i].idex_rd;
         bus.ext_stall     = vecs[i].ext_stall;
         bus.flush         = vecs[i].flush;
         #1;
         chk($sformatf("vec%0d_stall", i), {15'd0, bus.stall_out}, {15'd0, vecs[i].exp_stall});
         chk($sformatf("vec%0d_bubble", i), {15'd0, bus.bubble_out}, {15'd0, vecs[i].exp_bubble});
         chk($sformatf("vec%0d_halt", i), {15'd0, bus.halt_out}, {15'd0, vecs[i].exp_halt});
      end

      // Load-use: hold one cycle, then release when ID/EX holds the bubble
      place(16'hD9A0, 16'h0004, 1'b0);
      bus.use_rs        = 1'b1;
      bus.idex_valid    = 1'b1;
      bus.idex_mem_read = 1'b1;
      bus.idex_rd       = 3'd1;
      bus.instr_in      = 16'h1234;
      bus.pc2_in        = 16'h0006;
      tick();
      chk("lu_hold_instr", bus.instr_out, 16'hD9A0);
      chk("lu_hold_pc2", bus.pc2_out, 16'h0004);
      bus.idex_valid = 1'b0;
      #1;
      chk("lu_release_stall", {15'd0, bus.stall_out}, 16'd0);
      tick();
      chk("lu_next_instr", bus.instr_out, 16'h1234);
      chk("lu_next_pc2", bus.pc2_out, 16'h0006);

      // Flush beats ext_stall, clearing a latched error
      place(16'h4567, 16'h0008, 1'b1);
      chk("err_latched", {15'd0, bus.err_out}, 16'd1);
      bus.ext_stall = 1'b1;
      bus.flush     = 1'b1;
      bus.pc2_in    = 16'h00AA;
      tick();
      chk("fl_instr", bus.instr_out, 16'h0800);
      chk("fl_valid", {15'd0, bus.valid_out}, 16'd0);
      chk("fl_err", {15'd0, bus.err_out}, 16'd0);
      chk("fl_pc2", bus.pc2_out, 16'h00AA);

      // HALT holds for 10 cycles, then flush squashes it
      place(16'h0000, 16'h0020, 1'b0);
      for (int k = 0; k < 10; k++) begin
         bus.instr_in = 16'h8000 | 16'($urandom_range(0, 16'h7FFF));
         bus.pc2_in   = 16'($urandom);
         #1;
         chk("halt_flag", {15'd0, bus.halt_out}, 16'd1);
         chk("halt_stall", {15'd0, bus.stall_out}, 16'd1);
         tick();
         chk("halt_instr", bus.instr_out, 16'h0000);
         chk("halt_pc2", bus.pc2_out, 16'h0020);
      end
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      chk("halt_fl_valid", {15'd0, bus.valid_out}, 16'd0);
      chk("halt_fl_halt", {15'd0, bus.halt_out}, 16'd0);

      // Reset during stall
      place(16'h4567, 16'h0030, 1'b1);
      bus.ext_stall = 1'b1;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rs_instr", bus.instr_out, 16'h0800);
      chk("rs_pc2", bus.pc2_out, 16'h0000);
      chk("rs_valid", {15'd0, bus.valid_out}, 16'd0);
      chk("rs_err", {15'd0, bus.err_out}, 16'd0);

      // Random traffic against the reference model
      idle_inputs();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      m_instr = 16'h0800;
      m_pc2   = 16'h0000;
      m_valid = 1'b0;
      m_err   = 1'b0;
      for (int n = 0; n < 400; n++) begin
         rnd = 16'($urandom);
         if ($urandom_range(0, 7) == 0) rnd[15:11] = 5'b00000;
         else if (rnd[15:11] == 5'b00000) rnd[15:11] = 5'b00001;
         bus.instr_in      = rnd;
         bus.pc2_in        = 16'($urandom);
         bus.err_in        = ($urandom_range(0, 3) == 0);
         bus.flush         = ($urandom_range(0, 5) == 0);
         bus.ext_stall     = ($urandom_range(0, 4) == 0);
         bus.use_rs        = 1'($urandom);
         bus.use_rt        = 1'($urandom);
         bus.idex_valid    = 1'($urandom);
         bus.idex_mem_read = 1'($urandom);
         bus.idex_rd       = 3'($urandom);
         rst               = ($urandom_range(0, 49) == 0);
         #1;
         e_haz   = is_hazard(m_instr, m_valid);
         e_halt  = m_valid && (m_instr[15:11] == 5'b00000);
         e_stall = e_haz || bus.ext_stall || e_halt;
         chk("rnd_stall", {15'd0, bus.stall_out}, {15'd0, e_stall});
         chk("rnd_bubble", {15'd0, bus.bubble_out}, {15'd0, e_haz && !bus.flush});
         chk("rnd_halt", {15'd0, bus.halt_out}, {15'd0, e_halt});
         if (rst) begin
            m_instr = 16'h0800; m_pc2 = 16'h0000; m_valid = 1'b0; m_err = 1'b0;
         end else if (bus.flush) begin
            m_instr = 16'h0800; m_pc2 = bus.pc2_in; m_valid = 1'b0; m_err = 1'b0;
         end else if (!e_stall) begin
            m_instr = bus.instr_in; m_pc2 = bus.pc2_in; m_valid = 1'b1; m_err = bus.err_in;
         end
         tick();
         rst = 1'b0;
         chk("rnd_instr", bus.instr_out, m_instr);
         chk("rnd_pc2", bus.pc2_out, m_pc2);
         chk("rnd_valid", {15'd0, bus.valid_out}, {15'd0, m_valid});
         chk("rnd_err", {15'd0, bus.err_out}, {15'd0, m_err && m_valid});
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
